// File: rtl/synapse_mem_arbiter.sv
// Shares the single-port synapse SRAM between the OBI bus path and the charge-path word fetch.
// Define SYN_ARB_PERF_EN to add the free-running grant/stall performance counters.
module synapse_mem_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              inference_act_i,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic [3:0]        bus_be_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [DATA_W-1:0] bus_wdata_i,
    output logic              bus_gnt_o,
    output logic              bus_rvalid_o,
    output logic [DATA_W-1:0] bus_rdata_o,
    input  logic              core_req_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef SYN_ARB_PERF_EN
    ,
    output logic [31:0]       perf_core_gnt_o,
    output logic [31:0]       perf_bus_gnt_o,
    output logic [31:0]       perf_bus_stall_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        BUS  = 2'd2
    } state_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_core_q, resp_core_d;
    logic       resp_we_q, resp_we_d;
    logic       bus_win;
    logic       core_win;
    logic       starve_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            resp_valid_q <= 1'b0;
            resp_core_q  <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_core_q  <= resp_core_d;
            resp_we_q    <= resp_we_d;
        end
    end

    // The counter can only be non-zero after a core win, so the limit is checked in CORE only.
    assign starve_hit = (state_q == CORE) && (starve_cnt_q == STARVE_LIM);

    always_comb begin
        state_d = IDLE;
        if (bus_win) begin
            state_d = BUS;
        end else if (core_win) begin
            state_d = CORE;
        end

        starve_cnt_d = starve_cnt_q;
        if (bus_win || !bus_req_i) begin
            starve_cnt_d = '0;
        end else if (core_win && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end

        resp_valid_d = bus_win || core_win;
        resp_core_d  = core_win;
        resp_we_d    = bus_win && bus_we_i;
    end

    // Grants are suppressed while RST is high so nothing reaches the SRAM during reset.
    always_comb begin
        bus_win  = 1'b0;
        core_win = 1'b0;
        if (!RST) begin
            if (bus_req_i && core_req_i) begin
                if (inference_act_i && !starve_hit) begin
                    core_win = 1'b1;
                end else begin
                    bus_win = 1'b1;
                end
            end else begin
                bus_win  = bus_req_i;
                core_win = core_req_i;
            end
        end

        bus_gnt_o   = bus_win;
        core_gnt_o  = core_win;
        mem_req_o   = bus_win || core_win;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (bus_win) begin
            mem_we_o    = bus_we_i;
            mem_be_o    = bus_be_i;
            mem_addr_o  = bus_addr_i;
            mem_wdata_o = bus_wdata_i;
        end else if (core_win) begin
            mem_be_o    = 4'hF;
            mem_addr_o  = core_addr_i;
        end

        bus_rvalid_o  = resp_valid_q && !resp_core_q && !RST;
        core_rvalid_o = resp_valid_q && resp_core_q && !RST;
        bus_rdata_o   = (bus_rvalid_o && !resp_we_q) ? mem_rdata_i : '0;
        core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    end

`ifdef SYN_ARB_PERF_EN
    logic [31:0] perf_core_gnt_q, perf_core_gnt_d;
    logic [31:0] perf_bus_gnt_q, perf_bus_gnt_d;
    logic [31:0] perf_bus_stall_q, perf_bus_stall_d;

    always_comb begin
        perf_core_gnt_d  = perf_core_gnt_q + 32'(core_win);
        perf_bus_gnt_d   = perf_bus_gnt_q + 32'(bus_win);
        perf_bus_stall_d = perf_bus_stall_q + 32'(bus_req_i && !bus_win);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_core_gnt_q  <= '0;
            perf_bus_gnt_q   <= '0;
            perf_bus_stall_q <= '0;
        end else begin
            perf_core_gnt_q  <= perf_core_gnt_d;
            perf_bus_gnt_q   <= perf_bus_gnt_d;
            perf_bus_stall_q <= perf_bus_stall_d;
        end
    end

    assign perf_core_gnt_o  = perf_core_gnt_q;
    assign perf_bus_gnt_o   = perf_bus_gnt_q;
    assign perf_bus_stall_o = perf_bus_stall_q;
`endif

endmodule
